ipv4_fib_lpm: RTL and testbench

- Upstream neighbour of the IPv4 ARP table stage. Performs a longest-prefix-match lookup of an IPv4 destination against a software-managed FIB.
- Uses a sequential one-row-per-cycle scan.
- Emits the destination address, then the next hop and egress interface, in the pulse format the ARP stage consumes.
- Table management comes from the register interface and runs in the same clock domain.

---
 rtl/ipv4_fib_lpm.sv | 129 ++++++++++++
 tb/tb_ipv4_fib_lpm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_fib_lpm.sv
// ipv4_fib_lpm: longest-prefix-match FIB lookup that scans one row per cycle and emits its result in the pulse format the ARP stage consumes
module ipv4_fib_lpm #(
    parameter int FIB_ROWS     = 32,
    parameter int FIB_ROW_BITS = 5,
    parameter int OIF_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_lookup_req,
    input  logic [31:0]             i_lookup_daddr,
    output logic                    o_lookup_ready,
    output logic                    o_ipv4_daddr_valid,
    output logic [31:0]             o_ipv4_daddr,
    output logic                    o_fib_daddr_valid,
    output logic [31:0]             o_fib_daddr,
    output logic [OIF_WIDTH-1:0]    o_fib_oif,
    output logic                    o_fib_found,
    input  logic                    i_fib_rd_req,
    input  logic [FIB_ROW_BITS-1:0] i_fib_rd_addr,
    output logic                    o_fib_rd_ack,
    output logic [31:0]             o_fib_rd_prefix,
    output logic [31:0]             o_fib_rd_mask,
    output logic [31:0]             o_fib_rd_nexthop,
    output logic [OIF_WIDTH-1:0]    o_fib_rd_oif,
    input  logic                    i_fib_wr_req,
    input  logic [FIB_ROW_BITS-1:0] i_fib_wr_addr,
    input  logic [31:0]             i_fib_wr_prefix,
    input  logic [31:0]             i_fib_wr_mask,
    input  logic [31:0]             i_fib_wr_nexthop,
    input  logic [OIF_WIDTH-1:0]    i_fib_wr_oif,
    output logic                    o_fib_wr_ack
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state_q;
    logic [31:0]             prefix_q  [FIB_ROWS];
    logic [31:0]             mask_q    [FIB_ROWS];
    logic [31:0]             nexthop_q [FIB_ROWS];
    logic [OIF_WIDTH-1:0]    oif_q     [FIB_ROWS];
    logic [FIB_ROW_BITS-1:0] cnt_q, rd_addr_q;
    logic [31:0]             daddr_q, best_mask_q, best_nh_q, best_mask_d, best_nh_d;
    logic [OIF_WIDTH-1:0]    best_oif_q, best_oif_d;
    logic                    best_found_q, best_found_d, hit, better, last;
    assign o_lookup_ready   = state_q == IDLE && !reset;
    assign o_fib_rd_prefix  = prefix_q[rd_addr_q];
    assign o_fib_rd_mask    = mask_q[rd_addr_q];
    assign o_fib_rd_nexthop = nexthop_q[rd_addr_q];
    assign o_fib_rd_oif     = oif_q[rd_addr_q];
    assign last             = cnt_q == FIB_ROW_BITS'(FIB_ROWS - 1);
    // Only a strictly larger mask displaces the best, so ties keep the lower row.
    always_comb begin
        hit          = ((daddr_q & mask_q[cnt_q]) == (prefix_q[cnt_q] & mask_q[cnt_q])) && oif_q[cnt_q] != '0;
        better       = hit && (!best_found_q || mask_q[cnt_q] > best_mask_q);
        best_found_d = best_found_q || hit;
        best_mask_d  = better ? mask_q[cnt_q] : best_mask_q;
        best_nh_d    = better ? nexthop_q[cnt_q] : best_nh_q;
        best_oif_d   = better ? oif_q[cnt_q] : best_oif_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            rd_addr_q          <= '0;
            daddr_q            <= '0;
            best_found_q       <= 1'b0;
            best_mask_q        <= '0;
            best_nh_q          <= '0;
            best_oif_q         <= '0;
            o_ipv4_daddr_valid <= 1'b0;
            o_ipv4_daddr       <= '0;
            o_fib_daddr_valid  <= 1'b0;
            o_fib_daddr        <= '0;
            o_fib_oif          <= '0;
            o_fib_found        <= 1'b0;
            o_fib_rd_ack       <= 1'b0;
            o_fib_wr_ack       <= 1'b0;
            for (int r = 0; r < FIB_ROWS; r++) begin
                prefix_q[r]  <= '0;
                mask_q[r]    <= '0;
                nexthop_q[r] <= '0;
                oif_q[r]     <= '0;
            end
        end else begin
            o_ipv4_daddr_valid <= 1'b0;
            o_ipv4_daddr       <= '0;
            o_fib_daddr_valid  <= 1'b0;
            o_fib_daddr        <= '0;
            o_fib_oif          <= '0;
            o_fib_found        <= 1'b0;
            case (state_q)
                IDLE: if (i_lookup_req) begin
                    state_q            <= SCAN;
                    daddr_q            <= i_lookup_daddr;
                    cnt_q              <= '0;
                    best_found_q       <= 1'b0;
                    best_mask_q        <= '0;
                    best_nh_q          <= '0;
                    best_oif_q         <= '0;
                    o_ipv4_daddr_valid <= 1'b1;
                    o_ipv4_daddr       <= i_lookup_daddr;
                end
                SCAN: begin
                    best_found_q <= best_found_d;
                    best_mask_q  <= best_mask_d;
                    best_nh_q    <= best_nh_d;
                    best_oif_q   <= best_oif_d;
                    cnt_q        <= cnt_q + 1'b1;
                    if (last) begin
                        state_q           <= DONE;
                        o_fib_daddr_valid <= 1'b1;
                        o_fib_found       <= best_found_d;
                        o_fib_daddr       <= best_found_d ? best_nh_d : '0;
                        o_fib_oif         <= best_found_d ? best_oif_d : '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            o_fib_rd_ack <= i_fib_rd_req;
            o_fib_wr_ack <= i_fib_wr_req && !i_fib_rd_req;
            if (i_fib_rd_req) begin
                rd_addr_q <= i_fib_rd_addr;
            end else if (i_fib_wr_req) begin
                prefix_q[i_fib_wr_addr]  <= i_fib_wr_prefix;
                mask_q[i_fib_wr_addr]    <= i_fib_wr_mask;
                nexthop_q[i_fib_wr_addr] <= i_fib_wr_nexthop;
                oif_q[i_fib_wr_addr]     <= i_fib_wr_oif;
            end
        end
    end
endmodule

// File: tb/tb_ipv4_fib_lpm.sv
// tb_ipv4_fib_lpm: directed table-driven bench for the LPM FIB lookup
module tb_ipv4_fib_lpm;
    logic        clk = 1'b0, reset = 1'b1;
    logic        i_lookup_req = 1'b0;
    logic [31:0] i_lookup_daddr = '0;
    logic        o_lookup_ready, o_ipv4_daddr_valid, o_fib_daddr_valid, o_fib_found;
    logic [31:0] o_ipv4_daddr, o_fib_daddr;
    logic [7:0]  o_fib_oif;
    logic        i_fib_rd_req = 1'b0, o_fib_rd_ack;
    logic [4:0]  i_fib_rd_addr = '0;
    logic [31:0] o_fib_rd_prefix, o_fib_rd_mask, o_fib_rd_nexthop;
    logic [7:0]  o_fib_rd_oif;
    logic        i_fib_wr_req = 1'b0, o_fib_wr_ack;
    logic [4:0]  i_fib_wr_addr = '0;
    logic [31:0] i_fib_wr_prefix = '0, i_fib_wr_mask = '0, i_fib_wr_nexthop = '0;
    logic [7:0]  i_fib_wr_oif = '0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    ipv4_fib_lpm dut (
        .clk(clk), .reset(reset),
        .i_lookup_req(i_lookup_req), .i_lookup_daddr(i_lookup_daddr), .o_lookup_ready(o_lookup_ready),
        .o_ipv4_daddr_valid(o_ipv4_daddr_valid), .o_ipv4_daddr(o_ipv4_daddr),
        .o_fib_daddr_valid(o_fib_daddr_valid), .o_fib_daddr(o_fib_daddr), .o_fib_oif(o_fib_oif),
        .o_fib_found(o_fib_found),
        .i_fib_rd_req(i_fib_rd_req), .i_fib_rd_addr(i_fib_rd_addr), .o_fib_rd_ack(o_fib_rd_ack),
        .o_fib_rd_prefix(o_fib_rd_prefix), .o_fib_rd_mask(o_fib_rd_mask),
        .o_fib_rd_nexthop(o_fib_rd_nexthop), .o_fib_rd_oif(o_fib_rd_oif),
        .i_fib_wr_req(i_fib_wr_req), .i_fib_wr_addr(i_fib_wr_addr), .i_fib_wr_prefix(i_fib_wr_prefix),
        .i_fib_wr_mask(i_fib_wr_mask), .i_fib_wr_nexthop(i_fib_wr_nexthop), .i_fib_wr_oif(i_fib_wr_oif),
        .o_fib_wr_ack(o_fib_wr_ack)
    );
    typedef struct {
        logic        wr;
        logic [4:0]  row;
        logic [31:0] pfx, msk, nh;
        logic [7:0]  oif;
        logic [31:0] daddr;
        logic        exp_f;
        logic [31:0] exp_nh;
        logic [7:0]  exp_oif;
    } vec_t;
    vec_t v[9];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    task automatic wr_row(input logic [4:0] row, input logic [31:0] pfx, msk, nh, input logic [7:0] oif);
        @(negedge clk);
        i_fib_wr_req = 1'b1; i_fib_wr_addr = row; i_fib_wr_prefix = pfx;
        i_fib_wr_mask = msk; i_fib_wr_nexthop = nh; i_fib_wr_oif = oif;
        @(negedge clk);
        i_fib_wr_req = 1'b0;
        chk("wr_ack", 32'(o_fib_wr_ack), 32'd1);
    endtask
    task automatic rd_row(input logic [4:0] row, output logic [31:0] pfx, msk, nh, output logic [7:0] oif);
        @(negedge clk);
        i_fib_rd_req = 1'b1; i_fib_rd_addr = row;
        @(negedge clk);
        i_fib_rd_req = 1'b0;
        chk("rd_ack", 32'(o_fib_rd_ack), 32'd1);
        pfx = o_fib_rd_prefix; msk = o_fib_rd_mask; nh = o_fib_rd_nexthop; oif = o_fib_rd_oif;
    endtask
    task automatic wait_result(inout int c);
        while (!o_fib_daddr_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask
    task automatic lookup(input logic [31:0] a, output logic f, output logic [31:0] nh, output logic [7:0] oif, output int lat);
        @(negedge clk);
        i_lookup_req = 1'b1; i_lookup_daddr = a;
        @(negedge clk);
        i_lookup_req = 1'b0;
        chk("ipv4_valid", 32'(o_ipv4_daddr_valid), 32'd1);
        chk("ipv4_daddr", o_ipv4_daddr, a);
        lat = 1;
        wait_result(lat);
        f = o_fib_found; nh = o_fib_daddr; oif = o_fib_oif;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        logic        f;
        logic [31:0] nh, p, m;
        logic [7:0]  oif;
        int          lat, c, npulse, nready, first_at, second_at;
        v[0] = '{1'b1, 5'd0,  32'h0A000000, 32'hFF000000, 32'hC0A80101, 8'h01, 32'h0A010203, 1'b1, 32'hC0A80101, 8'h01};
        v[1] = '{1'b1, 5'd5,  32'h0A010000, 32'hFFFF0000, 32'h00000000, 8'h04, 32'h0A010203, 1'b1, 32'h00000000, 8'h04};
        v[2] = '{1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        8'h00, 32'h0A020001, 1'b1, 32'hC0A80101, 8'h01};
        v[3] = '{1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        8'h00, 32'h0B000001, 1'b0, 32'h00000000, 8'h00};
        v[4] = '{1'b1, 5'd31, 32'h00000000, 32'h00000000, 32'h0A0000FE, 8'h02, 32'h08080808, 1'b1, 32'h0A0000FE, 8'h02};
        v[5] = '{1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        8'h00, 32'h0B000001, 1'b1, 32'h0A0000FE, 8'h02};
        v[6] = '{1'b1, 5'd3,  32'h0A010000, 32'hFFFF0000, 32'h0A000001, 8'h08, 32'h0A010203, 1'b1, 32'h0A000001, 8'h08};
        v[7] = '{1'b1, 5'd20, 32'h0A010200, 32'hFFFFFF00, 32'h0A0000AA, 8'h10, 32'h0A010203, 1'b1, 32'h0A0000AA, 8'h10};
        v[8] = '{1'b1, 5'd7,  32'h0A010203, 32'hFFFFFFFF, 32'h11111111, 8'h00, 32'h0A010203, 1'b1, 32'h0A0000AA, 8'h10};
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(o_lookup_ready), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(o_lookup_ready), 32'd1);
            chk("idle_ipv4_valid", 32'(o_ipv4_daddr_valid), 32'd0);
            chk("idle_fib_valid", 32'(o_fib_daddr_valid), 32'd0);
        end
        rd_row(5'd7, p, m, nh, oif);
        chk("rd7_all", p | m | nh | 32'(oif), 32'd0);
        @(negedge clk);
        chk("rd_ack_drop", 32'(o_fib_rd_ack), 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (v[i].wr) wr_row(v[i].row, v[i].pfx, v[i].msk, v[i].nh, v[i].oif);
            lookup(v[i].daddr, f, nh, oif, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
            chk($sformatf("v%0d_found", i), 32'(f), 32'(v[i].exp_f));
            chk($sformatf("v%0d_nexthop", i), nh, v[i].exp_nh);
            chk($sformatf("v%0d_oif", i), 32'(oif), 32'(v[i].exp_oif));
        end
        rd_row(5'd5, p, m, nh, oif);
        chk("rd5_prefix", p, 32'h0A010000);
        chk("rd5_mask", m, 32'hFFFF0000);
        chk("rd5_oif", 32'(oif), 32'h04);
        // Back-to-back requests: only the idle cycles accept.
        @(negedge clk);
        i_lookup_req = 1'b1; i_lookup_daddr = 32'h0A010203;
        npulse = 0; nready = 0; first_at = 0; second_at = 0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (o_lookup_ready) nready++;
            if (o_fib_daddr_valid) begin
                npulse++;
                if (npulse == 1) first_at = i;
                if (npulse == 2) second_at = i;
            end
        end
        i_lookup_req = 1'b0;
        chk("stream_results", 32'(npulse), 32'd2);
        chk("stream_first_at", 32'(first_at), 32'd33);
        chk("stream_spacing", 32'(second_at - first_at), 32'd34);
        chk("stream_ready_cycles", 32'(nready), 32'd2);
        c = 0;
        wait_result(c);
        chk("stream_drain", 32'(o_fib_daddr_valid), 32'd1);
        @(negedge clk);
        i_lookup_req = 1'b1; i_lookup_daddr = 32'h0A010203;
        @(negedge clk);
        i_lookup_req = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_mid_reset", 32'(o_lookup_ready), 32'd0);
        reset = 1'b0;
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_fib_daddr_valid) npulse++;
        end
        chk("abort_no_pulse", 32'(npulse), 32'd0);
        rd_row(5'd31, p, m, nh, oif);
        chk("rd31_cleared", nh | 32'(oif), 32'd0);
        lookup(32'h0A010203, f, nh, oif, lat);
        chk("post_reset_latency", 32'(lat), 32'd33);
        chk("post_reset_found", 32'(f), 32'd0);
        chk("post_reset_oif", 32'(oif), 32'd0);
        // Writes during a scan: row 20 is still ahead, row 1 was already passed.
        @(negedge clk);
        i_lookup_req = 1'b1; i_lookup_daddr = 32'h0A010203;
        @(negedge clk);
        i_lookup_req = 1'b0;
        repeat (4) @(negedge clk);
        i_fib_wr_req = 1'b1; i_fib_wr_addr = 5'd20; i_fib_wr_prefix = 32'h0A010200;
        i_fib_wr_mask = 32'hFFFFFF00; i_fib_wr_nexthop = 32'h0A0000AA; i_fib_wr_oif = 8'h10;
        @(negedge clk);
        i_fib_wr_addr = 5'd1; i_fib_wr_prefix = 32'h0A010203;
        i_fib_wr_mask = 32'hFFFFFFFF; i_fib_wr_nexthop = 32'h22222222; i_fib_wr_oif = 8'h20;
        @(negedge clk);
        i_fib_wr_req = 1'b0;
        c = 7;
        wait_result(c);
        chk("scanwr_latency", 32'(c), 32'd33);
        chk("scanwr_nexthop", o_fib_daddr, 32'h0A0000AA);
        chk("scanwr_oif", 32'(o_fib_oif), 32'h10);
        lookup(32'h0A010203, f, nh, oif, lat);
        chk("host_route_nexthop", nh, 32'h22222222);
        chk("host_route_oif", 32'(oif), 32'h20);
        @(negedge clk);
        i_fib_rd_req = 1'b1; i_fib_rd_addr = 5'd2;
        i_fib_wr_req = 1'b1; i_fib_wr_addr = 5'd2; i_fib_wr_prefix = 32'hDEADBEEF;
        i_fib_wr_mask = 32'hFFFFFFFF; i_fib_wr_nexthop = 32'h12345678; i_fib_wr_oif = 8'h40;
        @(negedge clk);
        i_fib_rd_req = 1'b0; i_fib_wr_req = 1'b0;
        chk("collide_rd_ack", 32'(o_fib_rd_ack), 32'd1);
        chk("collide_wr_ack", 32'(o_fib_wr_ack), 32'd0);
        rd_row(5'd2, p, m, nh, oif);
        chk("collide_row_unchanged", p | m | nh | 32'(oif), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
